// File: rtl/dmem_lsu.sv
// -----------------------------------------------------------------------------
// dmem_lsu -- core-side load/store unit driving a word-wide synchronous
// rwmemory port (one-cycle read latency).
//
// It turns RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW requests into word accesses.
// Sub-word stores are done as read-modify-write. A request is rejected with
// resp_err=1, and no memory access is made, if it is misaligned or uses an
// illegal funct3.
//
// Ports
//   clock, reset              single clock; synchronous active-high reset
//   req_valid/req_ready       request handshake (req_ready=1 only in IDLE)
//   req_store, req_funct3     operation: store flag and RISC-V width code
//   req_addr, req_wdata       byte address and right-justified store data
//   resp_valid/resp_ready     response handshake; held until consumed
//   resp_rdata, resp_err      extended load data (0 for stores/errors), error
//   mem_en, mem_wen           rwmemory enable / write enable
//   mem_addr                  word address = req_addr[AW+1:2] (upper bits wrap)
//   mem_wdata, mem_rdata      rwmemory data_in / data_out
// -----------------------------------------------------------------------------
module dmem_lsu #(
  parameter  int MEMSIZE = 1024,
  localparam int AW      = $clog2(MEMSIZE)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_store,
  input  logic [2:0]    req_funct3,
  input  logic [31:0]   req_addr,
  input  logic [31:0]   req_wdata,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [31:0]   resp_rdata,
  output logic          resp_err,
  output logic          mem_en,
  output logic          mem_wen,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CAPT,
    S_WRITE,
    S_RESP
  } state_t;

  state_t      state_q;
  logic        store_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic [31:0] mem_wdata_q;

  // Next-value helpers computed from the registered request.
  logic        req_bad;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] rdata_d;
  logic [31:0] merged_d;

  // Illegal width codes, stores with the unsigned bit set, or misalignment.
  always_comb begin
    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    req_bad = 1'b0;
    case (req_funct3)
      3'b011, 3'b110, 3'b111: req_bad = 1'b1;
      3'b001, 3'b101:         req_bad = req_addr[0];
      3'b010:                 req_bad = (req_addr[1:0] != 2'b00);
      default:                req_bad = 1'b0;
    endcase
    if (req_store && req_funct3[2]) req_bad = 1'b1;
  end

  // Lane extraction for loads and lane merge for sub-word stores.
  always_comb begin
    byte_sel = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    half_sel = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    case (funct3_q)
      3'b000:  rdata_d = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  rdata_d = {{16{half_sel[15]}}, half_sel};
      3'b100:  rdata_d = {24'h0, byte_sel};
      3'b101:  rdata_d = {16'h0, half_sel};
      default: rdata_d = mem_rdata;
    endcase

    merged_d = mem_rdata;
    if (funct3_q[1:0] == 2'b00)
      merged_d[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    else
      merged_d[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q     <= S_IDLE;
      store_q     <= 1'b0;
      funct3_q    <= 3'b000;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      rdata_q     <= 32'h0;
      err_q       <= 1'b0;
      mem_wdata_q <= 32'h0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            store_q  <= req_store;
            funct3_q <= req_funct3;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            rdata_q  <= 32'h0;
            err_q    <= req_bad;
            if (req_bad) begin
              state_q <= S_RESP;
            end else if (req_store && req_funct3 == 3'b010) begin
              mem_wdata_q <= req_wdata;
              state_q     <= S_WRITE;
            end else begin
              state_q <= S_READ;
            end
          end
        end
        S_READ:  state_q <= S_CAPT;
        S_CAPT: begin
          if (store_q) begin
            mem_wdata_q <= merged_d;
            state_q     <= S_WRITE;
          end else begin
            rdata_q <= rdata_d;
            state_q <= S_RESP;
          end
        end
        S_WRITE: state_q <= S_RESP;
        S_RESP:  if (resp_ready) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Memory strobes are decoded from state; reset masks them so a WRITE
  // cycle that coincides with reset never reaches the memory.
  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign mem_en     = ((state_q == S_READ) || (state_q == S_WRITE)) && !reset;
  assign mem_wen    = (state_q == S_WRITE) && !reset;
  assign mem_addr   = addr_q[AW+1:2];
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// -----------------------------------------------------------------------------
// tb_dmem_lsu -- directed, table-driven bench for dmem_lsu with a behavioural
// 1024-word synchronous rwmemory attached to the memory port.
// -----------------------------------------------------------------------------
module tb_dmem_lsu;

  localparam int MEMSIZE = 1024;
  localparam int AW      = 10;

  logic          clock = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic          req_store;
  logic [2:0]    req_funct3;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;
  logic          resp_valid;
  logic          resp_ready;
  logic [31:0]   resp_rdata;
  logic          resp_err;
  logic          mem_en;
  logic          mem_wen;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;
  int rd_cnt   = 0;
  int wr_cnt   = 0;

  logic [31:0] mem [MEMSIZE];

  always #5 clock = ~clock;

  dmem_lsu #(.MEMSIZE(MEMSIZE)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_store  (req_store),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_en     (mem_en),
    .mem_wen    (mem_wen),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  // Behavioural rwmemory: one-cycle synchronous read, write on en&wen.
  always @(posedge clock) begin
    if (mem_en) begin
      if (mem_wen) begin
        mem[mem_addr] <= mem_wdata;
        wr_cnt++;
      end else begin
        mem_rdata <= mem[mem_addr];
        rd_cnt++;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    string       tag;
    logic        store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_rd;
    int          exp_wr;
  } vec_t;

  // Issue one request with resp_ready high; measure latency and memory traffic.
  task automatic run_txn(input vec_t v);
    int lat;
    check({v.tag, " req_ready"}, 32'(req_ready), 32'd1);
    req_store  = v.store;
    req_funct3 = v.funct3;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
    req_valid  = 1'b1;
    rd_cnt     = 0;
    wr_cnt     = 0;
    @(posedge clock); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 10) begin
      @(posedge clock); #1;
      lat++;
    end
    check({v.tag, " latency"}, 32'(lat), 32'(v.exp_lat));
    check({v.tag, " rdata"}, resp_rdata, v.exp_rdata);
    check({v.tag, " err"}, 32'(resp_err), 32'(v.exp_err));
    check({v.tag, " reads"}, 32'(rd_cnt), 32'(v.exp_rd));
    check({v.tag, " writes"}, 32'(wr_cnt), 32'(v.exp_wr));
    @(posedge clock); #1;
    check({v.tag, " resp_valid drop"}, 32'(resp_valid), 32'd0);
  endtask

  vec_t vecs [18];

  initial begin
    int lat;
    for (int i = 0; i < MEMSIZE; i++) mem[i] = 32'h0;

    //                tag              st  f3      addr          wdata          exp_rdata      err lat rd wr
    vecs[0]  = '{"SW 10",          1'b1, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 2, 0, 1};
    vecs[1]  = '{"LW 10",          1'b0, 3'b010, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0, 3, 1, 0};
    vecs[2]  = '{"LB 13",          1'b0, 3'b000, 32'h0000_0013, 32'h0,         32'hFFFF_FFDE, 1'b0, 3, 1, 0};
    vecs[3]  = '{"LBU 13",         1'b0, 3'b100, 32'h0000_0013, 32'h0,         32'h0000_00DE, 1'b0, 3, 1, 0};
    vecs[4]  = '{"LH 12",          1'b0, 3'b001, 32'h0000_0012, 32'h0,         32'hFFFF_DEAD, 1'b0, 3, 1, 0};
    vecs[5]  = '{"LHU 10",         1'b0, 3'b101, 32'h0000_0010, 32'h0,         32'h0000_BEEF, 1'b0, 3, 1, 0};
    vecs[6]  = '{"SW 20",          1'b1, 3'b010, 32'h0000_0020, 32'h1122_3344, 32'h0000_0000, 1'b0, 2, 0, 1};
    vecs[7]  = '{"SB 21",          1'b1, 3'b000, 32'h0000_0021, 32'h0000_00AA, 32'h0000_0000, 1'b0, 4, 1, 1};
    vecs[8]  = '{"LW 20 after SB", 1'b0, 3'b010, 32'h0000_0020, 32'h0,         32'h1122_AA44, 1'b0, 3, 1, 0};
    vecs[9]  = '{"SH 22",          1'b1, 3'b001, 32'h0000_0022, 32'h0000_5566, 32'h0000_0000, 1'b0, 4, 1, 1};
    vecs[10] = '{"LW 20 after SH", 1'b0, 3'b010, 32'h0000_0020, 32'h0,         32'h5566_AA44, 1'b0, 3, 1, 0};
    vecs[11] = '{"LW 22 misalign", 1'b0, 3'b010, 32'h0000_0022, 32'h0,         32'h0000_0000, 1'b1, 1, 0, 0};
    vecs[12] = '{"SH 01 misalign", 1'b1, 3'b001, 32'h0000_0001, 32'h0000_1234, 32'h0000_0000, 1'b1, 1, 0, 0};
    vecs[13] = '{"f3 011 illegal", 1'b0, 3'b011, 32'h0000_0010, 32'h0,         32'h0000_0000, 1'b1, 1, 0, 0};
    vecs[14] = '{"SBU illegal",    1'b1, 3'b100, 32'h0000_0010, 32'h0000_0055, 32'h0000_0000, 1'b1, 1, 0, 0};
    vecs[15] = '{"LB 1010 alias",  1'b0, 3'b000, 32'h0000_1010, 32'h0,         32'hFFFF_FFEF, 1'b0, 3, 1, 0};
    vecs[16] = '{"LH 11 misalign", 1'b0, 3'b001, 32'h0000_0011, 32'h0,         32'h0000_0000, 1'b1, 1, 0, 0};
    vecs[17] = '{"LW 1010 alias",  1'b0, 3'b010, 32'h0000_1010, 32'h0,         32'hDEAD_BEEF, 1'b0, 3, 1, 0};

    reset      = 1'b1;
    req_valid  = 1'b0;
    req_store  = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    resp_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;

    // Reset state.
    check("rst req_ready",  32'(req_ready),  32'd1);
    check("rst resp_valid", 32'(resp_valid), 32'd0);
    check("rst resp_err",   32'(resp_err),   32'd0);
    check("rst resp_rdata", resp_rdata,      32'h0);
    check("rst mem_en",     32'(mem_en),     32'd0);
    check("rst mem_wen",    32'(mem_wen),    32'd0);
    check("rst mem_addr",   32'(mem_addr),   32'd0);
    check("rst mem_wdata",  mem_wdata,       32'h0);

    foreach (vecs[i]) run_txn(vecs[i]);

    check("mem word 4", mem[4], 32'hDEAD_BEEF);
    check("mem word 8", mem[8], 32'h5566_AA44);

    // Reset while an SB sits in CAPT: no write, no response.
    req_store  = 1'b1;
    req_funct3 = 3'b000;
    req_addr   = 32'h0000_0010;
    req_wdata  = 32'h0000_0077;
    req_valid  = 1'b1;
    rd_cnt     = 0;
    wr_cnt     = 0;
    @(posedge clock); #1;          // accepted, now READ
    req_valid = 1'b0;
    @(posedge clock); #1;          // now CAPT
    check("rmw rst mem_en in CAPT", 32'(mem_en), 32'd0);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check("rmw rst req_ready",  32'(req_ready),  32'd1);
    check("rmw rst resp_valid", 32'(resp_valid), 32'd0);
    repeat (4) begin
      @(posedge clock); #1;
      check("rmw rst no resp", 32'(resp_valid), 32'd0);
    end
    check("rmw rst writes", 32'(wr_cnt), 32'd0);
    check("rmw rst reads",  32'(rd_cnt), 32'd1);
    check("rmw rst word 4", mem[4], 32'hDEAD_BEEF);

    // Back-pressure: resp_ready low for 5 cycles on an aliased LW.
    resp_ready = 1'b0;
    req_store  = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h0000_1010;
    req_valid  = 1'b1;
    @(posedge clock); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 10) begin
      @(posedge clock); #1;
      lat++;
    end
    check("bp latency", 32'(lat), 32'd3);
    repeat (5) begin
      check("bp resp_valid", 32'(resp_valid), 32'd1);
      check("bp rdata",      resp_rdata,      32'hDEAD_BEEF);
      check("bp err",        32'(resp_err),   32'd0);
      check("bp req_ready",  32'(req_ready),  32'd0);
      @(posedge clock); #1;
    end
    check("bp still valid", 32'(resp_valid), 32'd1);
    resp_ready = 1'b1;
    @(posedge clock); #1;
    check("bp released resp_valid", 32'(resp_valid), 32'd0);
    check("bp released req_ready",  32'(req_ready),  32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
